// File: rtl/dw_qsync_send_arbiter.sv
// rtl/dw_qsync_send_arbiter.sv - round-robin sequencer feeding one quasi-sync low-to-high source port
module dw_qsync_send_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk_s,
  input  logic                     rst_s,
  input  logic                     init_s,
  input  logic [NUM_REQ-1:0]       en_s,
  input  logic [NUM_REQ-1:0]       req_s,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_s,
  output logic [NUM_REQ-1:0]       gnt_s,
  output logic                     send_s,
  output logic [WIDTH-1:0]         data_s,
  output logic [IDW-1:0]           src_id_s,
  output logic                     busy_s
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  // Round-robin pointer: index that gets first look in the next scan.
  logic [IDW-1:0]     rr_ptr;
  // Idle cycles still owed before another send may be issued.
  logic [3:0]         gap_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic               ready;
  logic               found;
  logic               grant;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     win_next;
  logic [WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0] win_onehot;

  assign ready  = (gap_cnt == 4'd0);
  assign grant  = ready & found;
  assign busy_s = (gap_cnt != 4'd0) | send_s;

  // Scan requesters starting at rr_ptr and wrapping; the requester holding
  // this cycle's grant is masked so it cannot win again before it updates.
  always_comb begin : arb_scan
    int idx;
    eligible = req_s & en_s & ~gnt_s;
    found    = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Winner-derived values: word select, one-hot grant and the wrapped pointer.
  always_comb begin
    win_data   = req_data_s[int'(win)*WIDTH +: WIDTH];
    win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    win_next   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  // Output/state register: a grant launches one send pulse and reloads the
  // spacing counter; otherwise pulses drop and the counter drains.
  always_ff @(posedge clk_s) begin
    if (rst_s || init_s) begin
      send_s   <= 1'b0;
      gnt_s    <= '0;
      data_s   <= '0;
      src_id_s <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= 4'd0;
    end else if (grant) begin
      send_s   <= 1'b1;
      gnt_s    <= win_onehot;
      data_s   <= win_data;
      src_id_s <= win;
      rr_ptr   <= win_next;
      gap_cnt  <= GAP_LOAD;
    end else begin
      send_s   <= 1'b0;
      gnt_s    <= '0;
      if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  // Grant is at most one-hot and always accompanies the send pulse.
  a_gnt_onehot : assert property (@(posedge clk_s) $onehot0(gnt_s));
  a_send_gnt   : assert property (@(posedge clk_s) send_s == (|gnt_s));
  // While spacing is owed, no send may follow.
  a_spacing    : assert property (@(posedge clk_s) disable iff (rst_s || init_s)
                                  (gap_cnt != 4'd0) |=> !send_s);

endmodule

// File: tb/tb_dw_qsync_send_arbiter.sv
// tb/tb_dw_qsync_send_arbiter.sv - directed vector bench for dw_qsync_send_arbiter
module tb_dw_qsync_send_arbiter;

  logic        clk_s = 1'b0;
  logic        rst_s = 1'b1;
  logic        init_s = 1'b0;
  logic [3:0]  en_s = 4'b1111;
  logic [3:0]  req_a = 4'b0000;
  logic [3:0]  req_b = 4'b0000;
  logic [31:0] req_data_s = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  logic [3:0]  gnt_a, gnt_b;
  logic        send_a, send_b;
  logic [7:0]  data_a, data_b;
  logic [1:0]  id_a, id_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_s = ~clk_s;

  dw_qsync_send_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(1)) dut_a (
    .clk_s(clk_s), .rst_s(rst_s), .init_s(init_s), .en_s(en_s), .req_s(req_a),
    .req_data_s(req_data_s), .gnt_s(gnt_a), .send_s(send_a), .data_s(data_a),
    .src_id_s(id_a), .busy_s(busy_a)
  );

  dw_qsync_send_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(0)) dut_b (
    .clk_s(clk_s), .rst_s(rst_s), .init_s(init_s), .en_s(en_s), .req_s(req_b),
    .req_data_s(req_data_s), .gnt_s(gnt_b), .send_s(send_b), .data_s(data_b),
    .src_id_s(id_b), .busy_s(busy_b)
  );

  typedef struct {
    logic       rst;
    logic       init;
    logic [3:0] en;
    logic [3:0] req;
    logic       send;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic init, input logic [3:0] en,
                     input logic [3:0] req, input logic send, input logic [3:0] gnt,
                     input logic [1:0] id, input logic [7:0] data, input logic busy);
    vec_t v;
    v.rst = rst; v.init = init; v.en = en; v.req = req;
    v.send = send; v.gnt = gnt; v.id = id; v.data = data; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic check_b(input string name, input logic send, input logic [3:0] gnt,
                         input logic [1:0] id, input logic [7:0] data);
    @(negedge clk_s);
    @(posedge clk_s);
    #1;
    checks++;
    if (send_b !== send || gnt_b !== gnt || id_b !== id || data_b !== data || busy_b !== send) begin
      errors++;
      $display("FAIL %s: got send=%b gnt=%b id=%0d data=%h busy=%b, want send=%b gnt=%b id=%0d data=%h busy=%b",
               name, send_b, gnt_b, id_b, data_b, busy_b, send, gnt, id, data, send);
    end
  endtask

  initial begin
    // rst init en      req      send gnt      id  data   busy
    add(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'h00, 0);  // 0 reset held
    add(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'h00, 0);  // 1
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 8'hA0, 1);  // 2 first grant req0
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'hA0, 0);  // 3 gap
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 8'hA1, 1);  // 4
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 8'hA1, 0);  // 5
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 8'hA2, 1);  // 6
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 2, 8'hA2, 0);  // 7
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 8'hA3, 1);  // 8
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 3, 8'hA3, 0);  // 9
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 8'hA0, 1);  // 10 wrap
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'hA0, 0);  // 11
    add(0, 0, 4'b0101, 4'b1111, 1, 4'b0100, 2, 8'hA2, 1);  // 12 enable mask
    add(0, 0, 4'b0101, 4'b1111, 0, 4'b0000, 2, 8'hA2, 0);  // 13
    add(0, 0, 4'b0101, 4'b1111, 1, 4'b0001, 0, 8'hA0, 1);  // 14
    add(0, 0, 4'b0101, 4'b1111, 0, 4'b0000, 0, 8'hA0, 0);  // 15
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 8'hA1, 1);  // 16 re-enabled
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 8'hA1, 0);  // 17
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 8'hA2, 1);  // 18
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 2, 8'hA2, 0);  // 19
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 8'hA3, 1);  // 20
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 3, 8'hA3, 0);  // 21
    add(0, 1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'h00, 0);  // 22 init beats grant
    add(0, 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 8'hA0, 1);  // 23 req0 first again
    add(0, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 8'hA0, 0);  // 24
    add(0, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'hA0, 0);  // 25 no requests
    add(0, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'hA0, 0);  // 26
    add(0, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 8'hA0, 0);  // 27 all disabled
    add(0, 0, 4'b1111, 4'b0001, 1, 4'b0001, 0, 8'hA0, 1);  // 28 scan wraps to 0
    add(0, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'hA0, 0);  // 29
    add(0, 0, 4'b1111, 4'b1000, 1, 4'b1000, 3, 8'hA3, 1);  // 30
    add(0, 0, 4'b1111, 4'b1000, 0, 4'b0000, 3, 8'hA3, 0);  // 31
    add(0, 0, 4'b1111, 4'b1000, 1, 4'b1000, 3, 8'hA3, 1);  // 32 held req regrants

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_s);
      rst_s  = vecs[i].rst;
      init_s = vecs[i].init;
      en_s   = vecs[i].en;
      req_a  = vecs[i].req;
      @(posedge clk_s);
      #1;
      checks++;
      if (send_a !== vecs[i].send || gnt_a !== vecs[i].gnt || id_a !== vecs[i].id ||
          data_a !== vecs[i].data || busy_a !== vecs[i].busy) begin
        errors++;
        $display("FAIL vec%0d: got send=%b gnt=%b id=%0d data=%h busy=%b, want send=%b gnt=%b id=%0d data=%h busy=%b",
                 i, send_a, gnt_a, id_a, data_a, busy_a, vecs[i].send, vecs[i].gnt,
                 vecs[i].id, vecs[i].data, vecs[i].busy);
      end
    end

    // Zero-gap instance: two requesters alternate every cycle, a lone one every other cycle.
    @(negedge clk_s);
    req_a = 4'b0000;
    en_s  = 4'b1111;
    req_b = 4'b0101;
    @(posedge clk_s);
    #1;
    checks++;
    if (send_b !== 1'b1 || id_b !== 2'd0 || data_b !== 8'hA0) begin
      errors++;
      $display("FAIL b2b_0: got send=%b id=%0d data=%h, want send=1 id=0 data=a0", send_b, id_b, data_b);
    end
    check_b("b2b_1", 1, 4'b0100, 2, 8'hA2);
    check_b("b2b_2", 1, 4'b0001, 0, 8'hA0);
    check_b("b2b_3", 1, 4'b0100, 2, 8'hA2);
    @(negedge clk_s);
    req_b = 4'b0010;
    @(posedge clk_s);
    #1;
    checks++;
    if (send_b !== 1'b1 || gnt_b !== 4'b0010 || id_b !== 2'd1 || data_b !== 8'hA1) begin
      errors++;
      $display("FAIL single_0: got send=%b gnt=%b id=%0d data=%h, want send=1 gnt=0010 id=1 data=a1",
               send_b, gnt_b, id_b, data_b);
    end
    check_b("single_1", 0, 4'b0000, 1, 8'hA1);
    check_b("single_2", 1, 4'b0010, 1, 8'hA1);
    check_b("single_3", 0, 4'b0000, 1, 8'hA1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
